// File: rtl/char_console_if.sv
// Byte-stream input and character-RAM port of the text console writer.
// The console itself uses the slave view; whatever feeds bytes and hosts
// the RAM uses the master view.
interface char_console_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic [7:0]  in_attr;
   logic        in_ready;
   logic [1:0]  ram_we;
   logic [7:0]  ram_addr;
   logic [15:0] ram_data;
   logic [15:0] ram_q;

   modport slave (
      input  in_valid, in_data, in_attr, ram_q,
      output in_ready, ram_we, ram_addr, ram_data
   );

   modport master (
      output in_valid, in_data, in_attr, ram_q,
      input  in_ready, ram_we, ram_addr, ram_data
   );
endinterface

// File: rtl/char_console.sv
// Text-console writer for the tilemap character RAM.
// Interprets printable ASCII plus LF/CR/BS/FF, keeps a cursor, and performs
// clear-screen and hardware scroll by read-modify-write over one RAM port.
// RAM word address is {row, col} (fixed stride of 16 words per row).
module char_console #(
   parameter int COLS = 12,
   parameter int ROWS = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   char_console_if.slave       bus,
   output logic                busy,
   output logic [3:0]          cursor_col,
   output logic [3:0]          cursor_row
);

   typedef enum logic [2:0] {IDLE, PUT, CLR, SCR_RD, SCR_WR, SCR_CLR} state_t;

   localparam logic [3:0] LAST_COL = 4'(COLS - 1);
   localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
   // Last destination row of the copy phase of a scroll.
   localparam logic [3:0] LAST_DST = 4'(ROWS - 2);

   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_FF    = 8'h0C;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_SPACE = 8'h20;

   state_t      state_q,    state_d;
   logic [3:0]  col_q,      col_d;
   logic [3:0]  row_q,      row_d;
   logic [3:0]  scan_col_q, scan_col_d;   // cell addressed by CLR / scroll
   logic [3:0]  scan_row_q, scan_row_d;
   logic [7:0]  attr_q,     attr_d;       // attribute latched with the byte
   logic [1:0]  we_q,       we_d;
   logic [7:0]  addr_q,     addr_d;
   logic [15:0] data_q,     data_d;

   logic        printable;
   logic [3:0]  nxt_col;
   logic [3:0]  nxt_row;

   assign printable = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E);

   // Row-major successor of the scan cell (only used when one exists).
   assign nxt_col = (scan_col_q == LAST_COL) ? 4'd0 : scan_col_q + 4'd1;
   assign nxt_row = (scan_col_q == LAST_COL) ? scan_row_q + 4'd1 : scan_row_q;

   // Next-state, cursor and RAM-port decode. The RAM registers are loaded
   // with the access belonging to the state being entered, so each state
   // owns the port during its own cycle.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path
      // leaves one unassigned and no latch is inferred.
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      scan_col_d = scan_col_q;
      scan_row_d = scan_row_q;
      attr_d     = attr_q;
      we_d       = 2'b00;
      addr_d     = addr_q;
      data_d     = data_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               attr_d = bus.in_attr;
               if (printable) begin
                  state_d = PUT;
                  we_d    = 2'b11;
                  addr_d  = {row_q, col_q};
                  data_d  = {bus.in_attr, bus.in_data};
               end else begin
                  case (bus.in_data)
                     CH_LF: begin
                        col_d = 4'd0;
                        if (row_q == LAST_ROW) begin
                           state_d    = SCR_RD;
                           scan_row_d = 4'd0;
                           scan_col_d = 4'd0;
                           addr_d     = {4'd1, 4'd0};
                        end else begin
                           row_d = row_q + 4'd1;
                        end
                     end
                     CH_CR: col_d = 4'd0;
                     CH_BS: if (col_q != 4'd0) col_d = col_q - 4'd1;
                     CH_FF: begin
                        state_d    = CLR;
                        col_d      = 4'd0;
                        row_d      = 4'd0;
                        scan_row_d = 4'd0;
                        scan_col_d = 4'd0;
                        we_d       = 2'b11;
                        addr_d     = 8'h00;
                        data_d     = {bus.in_attr, CH_SPACE};
                     end
                     default: ;
                  endcase
               end
            end
         end

         PUT: begin
            if (col_q == LAST_COL) begin
               col_d = 4'd0;
               if (row_q == LAST_ROW) begin
                  state_d    = SCR_RD;
                  scan_row_d = 4'd0;
                  scan_col_d = 4'd0;
                  addr_d     = {4'd1, 4'd0};
               end else begin
                  row_d   = row_q + 4'd1;
                  state_d = IDLE;
               end
            end else begin
               col_d   = col_q + 4'd1;
               state_d = IDLE;
            end
         end

         CLR: begin
            if (scan_row_q == LAST_ROW && scan_col_q == LAST_COL) begin
               state_d = IDLE;
            end else begin
               scan_row_d = nxt_row;
               scan_col_d = nxt_col;
               we_d       = 2'b11;
               addr_d     = {nxt_row, nxt_col};
               data_d     = {attr_q, CH_SPACE};
            end
         end

         SCR_RD: begin
            state_d = SCR_WR;
            we_d    = 2'b11;
            addr_d  = {scan_row_q, scan_col_q};
         end

         SCR_WR: begin
            if (scan_row_q == LAST_DST && scan_col_q == LAST_COL) begin
               state_d    = SCR_CLR;
               scan_row_d = LAST_ROW;
               scan_col_d = 4'd0;
               we_d       = 2'b11;
               addr_d     = {LAST_ROW, 4'd0};
               data_d     = {attr_q, CH_SPACE};
            end else begin
               state_d    = SCR_RD;
               scan_row_d = nxt_row;
               scan_col_d = nxt_col;
               addr_d     = {nxt_row + 4'd1, nxt_col};
            end
         end

         SCR_CLR: begin
            if (scan_col_q == LAST_COL) begin
               state_d = IDLE;
            end else begin
               scan_col_d = scan_col_q + 4'd1;
               we_d       = 2'b11;
               addr_d     = {LAST_ROW, scan_col_q + 4'd1};
               data_d     = {attr_q, CH_SPACE};
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State, cursor and registered RAM port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         col_q      <= 4'd0;
         row_q      <= 4'd0;
         scan_col_q <= 4'd0;
         scan_row_q <= 4'd0;
         attr_q     <= 8'h00;
         we_q       <= 2'b00;
         addr_q     <= 8'h00;
         data_q     <= 16'h0000;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         scan_col_q <= scan_col_d;
         scan_row_q <= scan_row_d;
         attr_q     <= attr_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
      end
   end

   assign bus.in_ready = (state_q == IDLE);
   assign bus.ram_we   = we_q;
   assign bus.ram_addr = addr_q;
   // The scroll copy word arrives on ram_q in the SCR_WR cycle itself (read
   // address issued in SCR_RD, one-cycle RAM latency), so it is forwarded
   // straight to the write port instead of costing an extra cycle per cell.
   assign bus.ram_data = (state_q == SCR_WR) ? bus.ram_q : data_q;

   assign busy       = (state_q == CLR) || (state_q == SCR_RD) ||
                       (state_q == SCR_WR) || (state_q == SCR_CLR);
   assign cursor_col = col_q;
   assign cursor_row = row_q;

endmodule

// File: tb/tb_char_console.sv
// Directed self-checking bench for char_console with a behavioural
// character RAM (byte enables, one-cycle synchronous read latency).
module tb_char_console;

   localparam int COLS = 12;
   localparam int ROWS = 8;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       busy;
   logic [3:0] cursor_col;
   logic [3:0] cursor_row;

   char_console_if bus();

   char_console #(.COLS(COLS), .ROWS(ROWS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .busy       (busy),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [15:0] mem [0:255];
   logic        mem_loaded  = 1'b0;
   int          cyc         = 0;
   int          wr_count    = 0;
   int          busy_cycles = 0;
   int          bad_wr      = 0;
   int          last_accept = 0;
   int          prev_accept = 0;

   // Character RAM model; preloaded once with a marker pattern.
   always @(posedge clk) begin
      if (!mem_loaded) begin
         // NOTE: RAM contents are deliberately not touched by rst_n; the
         // pattern is loaded once so untouched cells stay recognisable.
         for (int i = 0; i < 256; i++) mem[i] <= 16'hE000 | 16'(i);
         mem_loaded <= 1'b1;
      end else begin
         if (bus.ram_we[0]) mem[bus.ram_addr][7:0]  <= bus.ram_data[7:0];
         if (bus.ram_we[1]) mem[bus.ram_addr][15:8] <= bus.ram_data[15:8];
      end
      bus.ram_q <= mem[bus.ram_addr];
   end

   // Activity monitor: cycles, busy cycles, writes, accept timestamps.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (busy) busy_cycles <= busy_cycles + 1;
      if (bus.in_valid && bus.in_ready) begin
         prev_accept <= last_accept;
         last_accept <= cyc;
      end
      if (bus.ram_we != 2'b00) begin
         wr_count <= wr_count + 1;
         if (int'(bus.ram_addr[3:0]) >= COLS) bad_wr <= bad_wr + 1;
      end
   end

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic send(input logic [7:0] d, input logic [7:0] a);
      int n = 0;
      while (!bus.in_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         tests_run++; tests_failed++;
         $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_attr  = a;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int limit, input string name);
      int n = 0;
      while (!(bus.in_ready && !busy) && n < limit) begin
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (!(bus.in_ready && !busy)) begin
         tests_failed++;
         $display("FAIL %s_idle: busy=%b after %0d cycles, required idle", name, busy, limit);
      end
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests_run++; if (bus.ram_we !== 2'b00) begin tests_failed++; $display("FAIL reset_we: got %b want 00", bus.ram_we); end
      tests_run++; if (bus.ram_addr !== 8'h00) begin tests_failed++; $display("FAIL reset_addr: got %h want 00", bus.ram_addr); end
      tests_run++; if (bus.ram_data !== 16'h0000) begin tests_failed++; $display("FAIL reset_data: got %h want 0000", bus.ram_data); end
      tests_run++; if ({cursor_row, cursor_col} !== 8'h00) begin tests_failed++; $display("FAIL reset_cursor: got row %0d col %0d want 0,0", cursor_row, cursor_col); end
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); end
   endtask

   task automatic test_single_char();
      int w0 = wr_count;
      send(8'h41, 8'h07);
      tests_run++; if (bus.ram_we !== 2'b11) begin tests_failed++; $display("FAIL put_we: got %b want 11", bus.ram_we); end
      tests_run++; if (bus.ram_addr !== 8'h00) begin tests_failed++; $display("FAIL put_addr: got %h want 00", bus.ram_addr); end
      tests_run++; if (bus.ram_data !== 16'h0741) begin tests_failed++; $display("FAIL put_data: got %h want 0741", bus.ram_data); end
      tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL put_ready_low: got %b want 0", bus.in_ready); end
      @(negedge clk);
      tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL put_ready_back: got %b want 1", bus.in_ready); end
      tests_run++; if (bus.ram_we !== 2'b00) begin tests_failed++; $display("FAIL put_we_after: got %b want 00", bus.ram_we); end
      tests_run++; if ({cursor_row, cursor_col} !== {4'd0, 4'd1}) begin tests_failed++; $display("FAIL put_cursor: got row %0d col %0d want 0,1", cursor_row, cursor_col); end
      tests_run++; if (wr_count - w0 !== 1) begin tests_failed++; $display("FAIL put_write_count: got %0d want 1", wr_count - w0); end
      tests_run++; if (mem[0] !== 16'h0741) begin tests_failed++; $display("FAIL put_ram: got %h want 0741", mem[0]); end
   endtask

   task automatic test_row_wrap();
      int errs = 0;
      send(8'h0D, 8'h02);
      tests_run++; if (cursor_col !== 4'd0 || bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL cr_cursor: got col %0d ready %b want 0 1", cursor_col, bus.in_ready); end
      for (int i = 0; i < COLS; i++) send(8'h61 + 8'(i), 8'h02);
      @(negedge clk);
      for (int i = 0; i < COLS; i++)
         if (mem[i] !== {8'h02, 8'h61 + 8'(i)}) errs++;
      tests_run++; if (errs !== 0) begin tests_failed++; $display("FAIL wrap_row0: got %0d bad cells want 0", errs); end
      tests_run++; if ({cursor_row, cursor_col} !== {4'd1, 4'd0}) begin tests_failed++; $display("FAIL wrap_cursor: got row %0d col %0d want 1,0", cursor_row, cursor_col); end
      tests_run++; if (last_accept - prev_accept !== 2) begin tests_failed++; $display("FAIL back_to_back_spacing: got %0d cycles want 2", last_accept - prev_accept); end
      send(8'h5A, 8'h02);
      tests_run++; if (bus.ram_addr !== 8'h10 || bus.ram_we !== 2'b11) begin tests_failed++; $display("FAIL wrap_next_addr: got %h we %b want 10 11", bus.ram_addr, bus.ram_we); end
      @(negedge clk);
   endtask

   task automatic test_scroll();
      int w0, b0, errs, k;
      logic [15:0] exp;
      pulse_reset();
      w0 = wr_count;
      b0 = busy_cycles;
      for (int i = 0; i < ROWS * COLS; i++) send(8'h21 + 8'(i % 64), 8'(i));
      @(negedge clk);
      tests_run++; if (busy !== 1'b1 || bus.ram_we !== 2'b00 || bus.ram_addr !== 8'h10) begin tests_failed++; $display("FAIL scroll_first_read: got busy %b we %b addr %h want 1 00 10", busy, bus.ram_we, bus.ram_addr); end
      tests_run++; if ({cursor_row, cursor_col} !== {4'd7, 4'd0}) begin tests_failed++; $display("FAIL scroll_cursor_early: got row %0d col %0d want 7,0", cursor_row, cursor_col); end
      wait_idle(400, "scroll");
      tests_run++; if (busy_cycles - b0 !== 180) begin tests_failed++; $display("FAIL scroll_busy_cycles: got %0d want 180", busy_cycles - b0); end
      tests_run++; if (wr_count - w0 !== 192) begin tests_failed++; $display("FAIL scroll_write_count: got %0d want 192", wr_count - w0); end
      errs = 0;
      for (int r = 0; r < ROWS - 1; r++)
         for (int c = 0; c < COLS; c++) begin
            k   = (r + 1) * COLS + c;
            exp = {8'(k), 8'h21 + 8'(k % 64)};
            if (mem[r * 16 + c] !== exp) errs++;
         end
      tests_run++; if (errs !== 0) begin tests_failed++; $display("FAIL scroll_rows_moved: got %0d bad cells want 0", errs); end
      errs = 0;
      for (int c = 0; c < COLS; c++) if (mem[7 * 16 + c] !== 16'h5F20) errs++;
      tests_run++; if (errs !== 0) begin tests_failed++; $display("FAIL scroll_last_row_blank: got %0d bad cells want 0", errs); end
      errs = 0;
      for (int r = 0; r < 16; r++)
         for (int c = COLS; c < 16; c++)
            if (mem[r * 16 + c] !== (16'hE000 | 16'(r * 16 + c))) errs++;
      tests_run++; if (errs !== 0 || bad_wr !== 0) begin tests_failed++; $display("FAIL scroll_hidden_cols: got %0d changed, %0d hidden writes want 0 0", errs, bad_wr); end
      tests_run++; if ({cursor_row, cursor_col} !== {4'd7, 4'd0}) begin tests_failed++; $display("FAIL scroll_cursor: got row %0d col %0d want 7,0", cursor_row, cursor_col); end
   endtask

   task automatic test_control();
      int w0;
      pulse_reset();
      w0 = wr_count;
      send(8'h58, 8'h33);
      @(negedge clk);
      tests_run++; if ({cursor_row, cursor_col} !== {4'd0, 4'd1}) begin tests_failed++; $display("FAIL ctrl_x_cursor: got row %0d col %0d want 0,1", cursor_row, cursor_col); end
      send(8'h08, 8'h33);
      tests_run++; if ({cursor_row, cursor_col} !== 8'h00 || bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL ctrl_bs1: got row %0d col %0d ready %b want 0,0 1", cursor_row, cursor_col, bus.in_ready); end
      send(8'h08, 8'h33);
      tests_run++; if ({cursor_row, cursor_col} !== 8'h00) begin tests_failed++; $display("FAIL ctrl_bs_saturate: got row %0d col %0d want 0,0", cursor_row, cursor_col); end
      tests_run++; if (last_accept - prev_accept !== 1) begin tests_failed++; $display("FAIL ctrl_back_to_back: got %0d cycles want 1", last_accept - prev_accept); end
      send(8'h0D, 8'h33);
      tests_run++; if ({cursor_row, cursor_col} !== 8'h00) begin tests_failed++; $display("FAIL ctrl_cr: got row %0d col %0d want 0,0", cursor_row, cursor_col); end
      send(8'h0A, 8'h33);
      tests_run++; if ({cursor_row, cursor_col} !== {4'd1, 4'd0}) begin tests_failed++; $display("FAIL ctrl_lf: got row %0d col %0d want 1,0", cursor_row, cursor_col); end
      send(8'h01, 8'h33);
      send(8'h7F, 8'h33);
      @(negedge clk);
      tests_run++; if ({cursor_row, cursor_col} !== {4'd1, 4'd0} || busy !== 1'b0) begin tests_failed++; $display("FAIL ctrl_ignored: got row %0d col %0d busy %b want 1,0 0", cursor_row, cursor_col, busy); end
      tests_run++; if (wr_count - w0 !== 1) begin tests_failed++; $display("FAIL ctrl_write_count: got %0d want 1", wr_count - w0); end
   endtask

   task automatic test_clear();
      int w0, b0, errs;
      w0 = wr_count;
      b0 = busy_cycles;
      send(8'h0C, 8'h1F);
      tests_run++; if ({cursor_row, cursor_col} !== 8'h00 || busy !== 1'b1) begin tests_failed++; $display("FAIL clear_start: got row %0d col %0d busy %b want 0,0 1", cursor_row, cursor_col, busy); end
      tests_run++; if (bus.ram_we !== 2'b11 || bus.ram_addr !== 8'h00 || bus.ram_data !== 16'h1F20) begin tests_failed++; $display("FAIL clear_first_write: got we %b addr %h data %h want 11 00 1f20", bus.ram_we, bus.ram_addr, bus.ram_data); end
      wait_idle(200, "clear");
      tests_run++; if (busy_cycles - b0 !== 96) begin tests_failed++; $display("FAIL clear_busy_cycles: got %0d want 96", busy_cycles - b0); end
      tests_run++; if (wr_count - w0 !== 96) begin tests_failed++; $display("FAIL clear_write_count: got %0d want 96", wr_count - w0); end
      errs = 0;
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++)
            if (r < ROWS && c < COLS) begin
               if (mem[r * 16 + c] !== 16'h1F20) errs++;
            end else if (c >= COLS) begin
               if (mem[r * 16 + c] !== (16'hE000 | 16'(r * 16 + c))) errs++;
            end
      tests_run++; if (errs !== 0 || bad_wr !== 0) begin tests_failed++; $display("FAIL clear_cells: got %0d bad cells, %0d hidden writes want 0 0", errs, bad_wr); end
      tests_run++; if ({cursor_row, cursor_col} !== 8'h00) begin tests_failed++; $display("FAIL clear_cursor: got row %0d col %0d want 0,0", cursor_row, cursor_col); end
   endtask

   task automatic test_reset_mid_scroll();
      for (int i = 0; i < ROWS - 1; i++) send(8'h0A, 8'h44);
      tests_run++; if ({cursor_row, cursor_col} !== {4'd7, 4'd0}) begin tests_failed++; $display("FAIL midrst_lf_row: got row %0d col %0d want 7,0", cursor_row, cursor_col); end
      send(8'h0A, 8'h44);
      repeat (50) @(negedge clk);
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL midrst_scrolling: got busy %b want 1", busy); end
      #2 rst_n = 1'b0;
      #1;
      tests_run++; if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_async_ctrl: got ready %b busy %b want 1 0", bus.in_ready, busy); end
      tests_run++; if (bus.ram_we !== 2'b00 || bus.ram_addr !== 8'h00 || bus.ram_data !== 16'h0000) begin tests_failed++; $display("FAIL midrst_async_ram: got we %b addr %h data %h want 00 00 0000", bus.ram_we, bus.ram_addr, bus.ram_data); end
      tests_run++; if ({cursor_row, cursor_col} !== 8'h00) begin tests_failed++; $display("FAIL midrst_async_cursor: got row %0d col %0d want 0,0", cursor_row, cursor_col); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++; if (bus.in_ready !== 1'b1 || busy !== 1'b0 || {cursor_row, cursor_col} !== 8'h00) begin tests_failed++; $display("FAIL midrst_release: got ready %b busy %b row %0d col %0d want 1 0 0,0", bus.in_ready, busy, cursor_row, cursor_col); end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.in_attr  = 8'h00;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_single_char();
      test_row_wrap();
      test_scroll();
      test_control();
      test_clear();
      test_reset_mid_scroll();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Global watchdog so a stuck design can never hang the run.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded 200000 time units, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
